// File: rtl/sync_down_counter_ld_if.sv
// Control and status bundle for the loadable down counter.
// The master drives the load/count controls; the slave (the counter) returns count and status.
interface sync_down_counter_ld_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             busy;
    logic             borrow_out;

    modport master (
        output en, load, din, mode,
        input  q, zero, tc, busy, borrow_out
    );

    modport slave (
        input  en, load, din, mode,
        output q, zero, tc, busy, borrow_out
    );
endinterface

// File: rtl/sync_down_counter_ld.sv
// Synchronous loadable down counter with one-shot, auto-reload and wrap modes.
// All state advances on the falling edge of clk; rst is asynchronous and active-low.
module sync_down_counter_ld #(
    parameter int WIDTH = 3
) (
    input logic                  clk,
    input logic                  rst,
    sync_down_counter_ld_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0]       MODE_AUTO = 2'b01;
    localparam logic [1:0]       MODE_WRAP = 2'b10;
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_s;
    logic             tc_r;
    logic             tc_s;
    logic             busy_r;

    // Next-state and next-count decode; load wins over en in every state.
    always_comb begin
        state_s  = state_r;
        q_s      = q_r;
        reload_s = reload_r;
        mode_s   = mode_r;
        tc_s     = 1'b0;
        if (bus.load) begin
            q_s      = bus.din;
            reload_s = bus.din;
            mode_s   = bus.mode;
            if ((bus.din != CNT_ZERO) || (bus.mode == MODE_WRAP)) begin
                state_s = RUN;
            end else begin
                state_s = DONE;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (!bus.en) begin
                        state_s = RUN;
                    end else if (q_r > CNT_ONE) begin
                        q_s = q_r - CNT_ONE;
                    end else if (q_r == CNT_ONE) begin
                        q_s  = CNT_ZERO;
                        tc_s = 1'b1;
                        if ((mode_r == MODE_AUTO) || (mode_r == MODE_WRAP)) begin
                            state_s = RUN;
                        end else begin
                            state_s = DONE;
                        end
                    end else begin
                        // Count already at zero: reload, wrap, or settle (reserved acts as one-shot).
                        case (mode_r)
                            MODE_AUTO: q_s = reload_r;
                            MODE_WRAP: q_s = CNT_MAX;
                            default:   state_s = DONE;
                        endcase
                    end
                end
                IDLE:    state_s = IDLE;
                DONE:    state_s = DONE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Falling-edge state and output registers with asynchronous clear.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            q_r      <= CNT_ZERO;
            reload_r <= CNT_ZERO;
            mode_r   <= 2'b00;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            q_r      <= q_s;
            reload_r <= reload_s;
            mode_r   <= mode_s;
            tc_r     <= tc_s;
            busy_r   <= (state_s == RUN);
        end
    end

    assign bus.q          = q_r;
    assign bus.tc         = tc_r;
    assign bus.busy       = busy_r;
    assign bus.zero       = (q_r == CNT_ZERO);
    assign bus.borrow_out = bus.en & (q_r == CNT_ZERO) & busy_r;

endmodule

// File: tb/tb_sync_down_counter_ld.sv
// Bench for sync_down_counter_ld: directed vector table, a mid-count reset sequence,
// and a randomized run checked against a count-level reference model.
module tb_sync_down_counter_ld;

    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sync_down_counter_ld_if #(.WIDTH(W)) bus ();

    sync_down_counter_ld #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ld;
        logic         en;
        logic [W-1:0] din;
        logic [1:0]   mode;
        logic [W-1:0] q;
        logic         tc;
        logic         busy;
    } vec_t;

    vec_t vecs[$];

    // Reference model: remaining count, armed flag and captured configuration.
    int m_q;
    int m_reload;
    int m_mode;
    bit m_run;
    bit m_tc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic ld, input logic e, input logic [W-1:0] d, input logic [1:0] m);
        @(posedge clk);
        bus.load = ld;
        bus.en   = e;
        bus.din  = d;
        bus.mode = m;
        @(negedge clk);
        #1;
    endtask

    task automatic add(input logic ld, input logic e, input int d, input int m,
                       input int q, input logic tc, input logic busy);
        vec_t v;
        v.ld = ld; v.en = e; v.din = W'(d); v.mode = 2'(m);
        v.q = W'(q); v.tc = tc; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_q = 0; m_reload = 0; m_mode = 0; m_run = 1'b0; m_tc = 1'b0;
    endtask

    task automatic model_edge(input bit ld, input bit e, input int d, input int m);
        bit one_shot;
        if (ld) begin
            m_q = d; m_reload = d; m_mode = m; m_tc = 1'b0;
            m_run = (d != 0) || (m == 2);
        end else if (m_run && e) begin
            one_shot = !(m_mode == 1 || m_mode == 2);
            if (m_q != 0) begin
                m_q  = m_q - 1;
                m_tc = (m_q == 0);
                if (m_q == 0 && one_shot) m_run = 1'b0;
            end else begin
                m_tc = 1'b0;
                if (m_mode == 1) m_q = m_reload;
                else if (m_mode == 2) m_q = (m_q + MAXV + 1 - 1) % (MAXV + 1);
                else m_run = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        @(posedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.load = 1'b0; bus.en = 1'b0; bus.din = '0; bus.mode = 2'b00;
        #3;
        check("reset_q", bus.q, 0);
        check("reset_tc", bus.tc, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_zero", bus.zero, 1);
        check("reset_borrow", bus.borrow_out, 0);
        @(posedge clk);
        rst = 1'b1;

        // Reset in the middle of a count, with no clock edge before checking.
        step(1'b1, 1'b0, 3'd5, 2'b00);
        step(1'b0, 1'b1, 3'd0, 2'b00);
        step(1'b0, 1'b1, 3'd0, 2'b00);
        check("midcount_q_before", bus.q, 3);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_q", bus.q, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_tc", bus.tc, 0);
        check("midrst_zero", bus.zero, 1);
        check("midrst_borrow", bus.borrow_out, 0);
        @(posedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 3'd0, 2'b00);
        check("idle_ignores_en_q", bus.q, 0);
        check("idle_ignores_en_busy", bus.busy, 0);

        // One-shot from 5.
        add(1, 0, 5, 0, 5, 0, 1);
        add(0, 1, 0, 0, 4, 0, 1);
        add(0, 1, 0, 0, 3, 0, 1);
        add(0, 1, 0, 0, 2, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0);
        // Auto-reload from 3.
        add(1, 0, 3, 1, 3, 0, 1);
        add(0, 1, 0, 0, 2, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 3, 0, 1);
        add(0, 1, 0, 0, 2, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 3, 0, 1);
        add(0, 1, 0, 0, 2, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        // Free-run wrap loaded with zero.
        add(1, 0, 0, 2, 0, 0, 1);
        for (int k = 7; k >= 1; k--) add(0, 1, 0, 0, k, 0, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 7, 0, 1);
        // Hold with en low, then load beats en.
        add(1, 0, 6, 0, 6, 0, 1);
        add(0, 1, 0, 0, 5, 0, 1);
        add(0, 1, 0, 0, 4, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4, 0, 1);
        add(1, 1, 2, 0, 2, 0, 1);
        // Zero load in one-shot, then load 1.
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        // Reserved mode behaves as one-shot.
        add(1, 0, 2, 3, 2, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].en, vecs[i].din, vecs[i].mode);
            check($sformatf("vec%0d_q", i), bus.q, vecs[i].q);
            check($sformatf("vec%0d_tc", i), bus.tc, vecs[i].tc);
            check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
            check($sformatf("vec%0d_zero", i), bus.zero, (vecs[i].q == 0));
            check($sformatf("vec%0d_borrow", i), bus.borrow_out,
                  vecs[i].en & (vecs[i].q == 0) & vecs[i].busy);
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit ld;
            bit e;
            int d;
            int m;
            ld = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, MAXV);
            m  = $urandom_range(0, 3);
            step(ld, e, W'(d), 2'(m));
            model_edge(ld, e, d, m);
            check("rand_q", bus.q, m_q);
            check("rand_tc", bus.tc, m_tc);
            check("rand_busy", bus.busy, m_run);
            check("rand_zero", bus.zero, (m_q == 0));
            check("rand_borrow", bus.borrow_out, e && (m_q == 0) && m_run);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
